// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: datapath widths, the ALU
// opcode map, and the arbiter FSM state type.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;   // holds SETTLE_CYCLES-1 for 1..15

    localparam logic [OP_W-1:0] OP_FWD = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-drive bundle for alu_arbiter.
//   slave  : the arbiter's view (takes requests and ALU result, drives grants,
//            done pulses, captured results and the ALU inputs)
//   master : the surrounding datapath's view (requesters plus the ALU)
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              REQ0, REQ1;
    logic [OP_W-1:0]   OP0, OP1;
    logic [DATA_W-1:0] A0, A1, B0, B1;
    logic              GNT0, GNT1;
    logic              DONE0, DONE1;
    logic [DATA_W-1:0] RES0, RES1;
    logic              ZF0, ZF1;
    logic [DATA_W-1:0] ALU_DATA1, ALU_DATA2;
    logic [OP_W-1:0]   ALU_SELECT;
    logic [DATA_W-1:0] ALU_RESULT;
    logic              ALU_ZERO;

    modport slave (
        input  REQ0, REQ1, OP0, OP1, A0, A1, B0, B1, ALU_RESULT, ALU_ZERO,
        output GNT0, GNT1, DONE0, DONE1, RES0, RES1, ZF0, ZF1,
               ALU_DATA1, ALU_DATA2, ALU_SELECT
    );

    modport master (
        output REQ0, REQ1, OP0, OP1, A0, A1, B0, B1, ALU_RESULT, ALU_ZERO,
        input  GNT0, GNT1, DONE0, DONE1, RES0, RES1, ZF0, ZF1,
               ALU_DATA1, ALU_DATA2, ALU_SELECT
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req0_i, req1_i : requests
//   last_i         : port served most recently (owned by the parent)
//   valid_o        : at least one request present
//   win_o          : winning port index
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic win_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        // On a tie the port not served last wins; otherwise the lone requester.
        win_o   = (req0_i & req1_i) ? ~last_i : req1_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU between two requesters. The winner's
// opcode/operands are latched onto the ALU inputs and held for SETTLE_CYCLES
// edges, then RESULT/ZERO are captured into that port's RES/ZF and DONE pulses.
//   CLK, RESET_N : clock (rising edge), asynchronous active-low reset
//   bus          : request/grant/done handshake and ALU drive (slave view)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    alu_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [OP_W-1:0]   sel_q,   sel_d;
    logic [DATA_W-1:0] res0_q,  res0_d, res1_q, res1_d;
    logic              zf0_q,   zf0_d,  zf1_q,  zf1_d;
    logic              gnt0_q,  gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;

    logic arb_valid, arb_win;

    rr_arbiter2 u_arb (
        .req0_i  (bus.REQ0),
        .req1_i  (bus.REQ1),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .win_o   (arb_win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data1_d = data1_q;
        data2_d = data2_q;
        sel_d   = sel_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        zf0_d   = zf0_q;
        zf1_d   = zf1_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_win;
                    sel_d   = arb_win ? bus.OP1 : bus.OP0;
                    data1_d = arb_win ? bus.A1  : bus.A0;
                    data2_d = arb_win ? bus.B1  : bus.B0;
                    cnt_d   = CNT_INIT;
                    gnt0_d  = ~arb_win;
                    gnt1_d  = arb_win;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (owner_q) begin
                        res1_d  = bus.ALU_RESULT;
                        zf1_d   = bus.ALU_ZERO;
                        done1_d = 1'b1;
                    end else begin
                        res0_d  = bus.ALU_RESULT;
                        zf0_d   = bus.ALU_ZERO;
                        done0_d = 1'b1;
                    end
                    last_d  = owner_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
            sel_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            zf0_q   <= 1'b0;
            zf1_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            sel_q   <= sel_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            zf0_q   <= zf0_d;
            zf1_q   <= zf1_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign bus.GNT0       = gnt0_q;
    assign bus.GNT1       = gnt1_q;
    assign bus.DONE0      = done0_q;
    assign bus.DONE1      = done1_q;
    assign bus.RES0       = res0_q;
    assign bus.RES1       = res1_q;
    assign bus.ZF0        = zf0_q;
    assign bus.ZF1        = zf1_q;
    assign bus.ALU_DATA1  = data1_q;
    assign bus.ALU_DATA2  = data2_q;
    assign bus.ALU_SELECT = sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the drive bus.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned SETTLE = 2;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLK = ~CLK;

    alu_arbiter_if bus();

    alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] alu_model(input logic [2:0] sel,
                                             input logic [7:0] d1,
                                             input logic [7:0] d2);
        case (sel)
            OP_FWD:  return d2;
            OP_ADD:  return d1 + d2;
            OP_AND:  return d1 & d2;
            OP_OR:   return d1 | d2;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.ALU_RESULT = alu_model(bus.ALU_SELECT, bus.ALU_DATA1, bus.ALU_DATA2);
    assign bus.ALU_ZERO   = (bus.ALU_RESULT == 8'h00);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"},  32'(bus.GNT0),  0);
        check({tag, "_gnt1"},  32'(bus.GNT1),  0);
        check({tag, "_done0"}, 32'(bus.DONE0), 0);
        check({tag, "_done1"}, 32'(bus.DONE1), 0);
        check({tag, "_res0"},  32'(bus.RES0),  0);
        check({tag, "_res1"},  32'(bus.RES1),  0);
        check({tag, "_zf0"},   32'(bus.ZF0),   0);
        check({tag, "_zf1"},   32'(bus.ZF1),   0);
        check({tag, "_d1"},    32'(bus.ALU_DATA1),  0);
        check({tag, "_d2"},    32'(bus.ALU_DATA2),  0);
        check({tag, "_sel"},   32'(bus.ALU_SELECT), 0);
    endtask

    task automatic apply_reset(input string tag);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        RESET_N = 1'b0;
        #2;
        check_reset_outputs(tag);
        step();
        step();
        RESET_N = 1'b1;
        step();
    endtask

    // Issue one request, wait (bounded) for its DONE and check latency/result.
    task automatic run_op(input int port, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r,
                          input logic exp_z, input string tag);
        int n;
        logic seen, other;
        n = 0; seen = 1'b0; other = 1'b0;
        if (port == 0) begin
            bus.OP0 = op; bus.A0 = a; bus.B0 = b; bus.REQ0 = 1'b1;
        end else begin
            bus.OP1 = op; bus.A1 = a; bus.B1 = b; bus.REQ1 = 1'b1;
        end
        while (!seen && n < 20) begin
            step();
            n++;
            if (port == 0) begin
                seen  = bus.DONE0;
                other = other | bus.DONE1 | bus.GNT1;
            end else begin
                seen  = bus.DONE1;
                other = other | bus.DONE0 | bus.GNT0;
            end
        end
        check({tag, "_lat"},   32'(n), 32'(SETTLE + 1));
        check({tag, "_res"},   32'(port == 0 ? bus.RES0 : bus.RES1), 32'(exp_r));
        check({tag, "_zf"},    32'(port == 0 ? bus.ZF0 : bus.ZF1), 32'(exp_z));
        check({tag, "_other"}, 32'(other), 0);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        step();
        check({tag, "_done_off"}, 32'(port == 0 ? bus.DONE0 : bus.DONE1), 0);
        check({tag, "_gnt_off"},  32'(port == 0 ? bus.GNT0 : bus.GNT1), 0);
    endtask

    initial begin
        int ndone, overlap, last_cyc, cyc;
        int order[6];
        logic nodone;

        bus.REQ0 = 0; bus.REQ1 = 0;
        bus.OP0 = '0; bus.OP1 = '0;
        bus.A0 = '0; bus.A1 = '0; bus.B0 = '0; bus.B1 = '0;
        #2;
        apply_reset("rst");

        // Port 0 alone: 5 + 3, cycle-by-cycle timing.
        bus.OP0 = OP_ADD; bus.A0 = 8'h05; bus.B0 = 8'h03; bus.REQ0 = 1'b1;
        step();
        check("t1_gnt0_rise", 32'(bus.GNT0), 1);
        check("t1_gnt1",      32'(bus.GNT1), 0);
        check("t1_sel",       32'(bus.ALU_SELECT), 1);
        check("t1_d1",        32'(bus.ALU_DATA1), 32'h05);
        check("t1_d2",        32'(bus.ALU_DATA2), 32'h03);
        step();
        check("t1_done0_early", 32'(bus.DONE0), 0);
        check("t1_gnt0_hold",   32'(bus.GNT0), 1);
        step();
        check("t1_done0",    32'(bus.DONE0), 1);
        check("t1_res0",     32'(bus.RES0), 32'h08);
        check("t1_zf0",      32'(bus.ZF0), 0);
        check("t1_gnt0_dn",  32'(bus.GNT0), 1);
        bus.REQ0 = 1'b0;
        step();
        check("t1_done0_off", 32'(bus.DONE0), 0);
        check("t1_gnt0_off",  32'(bus.GNT0), 0);
        check("t1_res1",      32'(bus.RES1), 0);
        check("t1_zf1",       32'(bus.ZF1), 0);
        check("t1_done1",     32'(bus.DONE1), 0);
        step();
        check("t1_idle_d1",   32'(bus.ALU_DATA1), 32'h05);
        check("t1_idle_sel",  32'(bus.ALU_SELECT), 1);
        check("t1_res0_hold", 32'(bus.RES0), 32'h08);

        // Tie from reset: port 0 (0xF0 & 0x0F) first, then port 1 forward 0x7E.
        apply_reset("rst2");
        bus.OP0 = OP_AND; bus.A0 = 8'hF0; bus.B0 = 8'h0F;
        bus.OP1 = OP_FWD; bus.A1 = 8'h55; bus.B1 = 8'h7E;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        ndone = 0; overlap = 0; cyc = 0;
        while (ndone < 2 && cyc < 30) begin
            step();
            cyc++;
            if (bus.GNT0 && bus.GNT1) overlap = 1;
            if (bus.DONE0) begin
                order[ndone] = 0; ndone++;
                check("t2_res0", 32'(bus.RES0), 32'h00);
                check("t2_zf0",  32'(bus.ZF0), 1);
                bus.REQ0 = 1'b0;
            end
            if (bus.DONE1) begin
                order[ndone] = 1; ndone++;
                check("t2_res1", 32'(bus.RES1), 32'h7E);
                check("t2_zf1",  32'(bus.ZF1), 0);
                bus.REQ1 = 1'b0;
            end
        end
        check("t2_ndone",   32'(ndone), 2);
        check("t2_first",   32'(order[0]), 0);
        check("t2_second",  32'(order[1]), 1);
        check("t2_overlap", 32'(overlap), 0);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        step();

        // Six back-to-back ties: strict alternation, SETTLE+2 spacing.
        bus.OP0 = OP_ADD; bus.A0 = 8'h01; bus.B0 = 8'h01;
        bus.OP1 = OP_OR;  bus.A1 = 8'h30; bus.B1 = 8'h03;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        ndone = 0; cyc = 0; last_cyc = 0;
        while (ndone < 6 && cyc < 60) begin
            step();
            cyc++;
            if (bus.DONE0 || bus.DONE1) begin
                order[ndone] = bus.DONE1 ? 1 : 0;
                check("t3_order", 32'(order[ndone]), 32'(ndone % 2));
                if (ndone > 0) check("t3_spacing", 32'(cyc - last_cyc), 32'(SETTLE + 2));
                if (bus.DONE0) check("t3_res0", 32'(bus.RES0), 32'h02);
                else           check("t3_res1", 32'(bus.RES1), 32'h33);
                last_cyc = cyc;
                ndone++;
            end
        end
        check("t3_ndone", 32'(ndone), 6);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        step();

        // Operand change while busy is ignored.
        bus.OP0 = OP_ADD; bus.A0 = 8'h05; bus.B0 = 8'h03; bus.REQ0 = 1'b1;
        step();
        check("t4_gnt0", 32'(bus.GNT0), 1);
        bus.A0 = 8'h40; bus.OP0 = OP_AND; bus.B0 = 8'hFF;
        step();
        check("t4_d1_held",  32'(bus.ALU_DATA1), 32'h05);
        check("t4_sel_held", 32'(bus.ALU_SELECT), 1);
        cyc = 0;
        while (!bus.DONE0 && cyc < 10) begin
            step();
            cyc++;
        end
        check("t4_done0", 32'(bus.DONE0), 1);
        check("t4_res0",  32'(bus.RES0), 32'h08);
        check("t4_zf0",   32'(bus.ZF0), 0);
        bus.REQ0 = 1'b0;
        step();

        // Undefined opcode on port 1 yields zero with ZERO set.
        run_op(1, 3'b111, 8'h12, 8'h34, 8'h00, 1'b1, "t5_op7");

        // Reset in the middle of a transaction.
        bus.OP0 = OP_ADD; bus.A0 = 8'h09; bus.B0 = 8'h09; bus.REQ0 = 1'b1;
        step();
        check("t6_gnt0", 32'(bus.GNT0), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        bus.REQ0 = 1'b0;
        step();
        step();
        RESET_N = 1'b1;
        nodone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.DONE0 || bus.DONE1 || bus.GNT0) nodone = 1'b0;
        end
        check("t6_no_done", 32'(nodone), 1);
        run_op(0, OP_ADD, 8'h09, 8'h09, 8'h12, 1'b0, "t6_reissue");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
